alu_op_sequencer: RTL

Control stage directly upstream of the ALU16 16:1 result-select mux. It accepts one ALU opcode at a time through a valid/ready handshake and drives the mux's 4-bit select. For iterative operations (MUL, DIV) it sequences the shift/add datapath for W cycles, then captures the mux output into a result register with status flags. The result is presented downstream under a valid/ready handshake.

---
 rtl/alu_op_sequencer_if.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundle between the opcode source, the ALU16 shift/add datapath, the result mux
// and the result consumer. The sequencer connects through the slave modport.
interface alu_op_sequencer_if #(
  parameter int W = 16
) ();
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  // opcode handshake
  logic          op_valid;
  logic          op_ready;
  logic [3:0]    opcode;

  // datapath control and result-mux select
  logic          dp_load;
  logic          step_en;
  logic [CW-1:0] step_cnt;
  logic [3:0]    sel;
  logic [W-1:0]  mux_out;
  logic          c_in;
  logic          v_in;

  // result handshake
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  result;
  logic          flag_z;
  logic          flag_n;
  logic          flag_c;
  logic          flag_v;

  modport master (
    output op_valid, opcode, mux_out, c_in, v_in, res_ready,
    input  op_ready, dp_load, step_en, step_cnt, sel,
    input  res_valid, result, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  op_valid, opcode, mux_out, c_in, v_in, res_ready,
    output op_ready, dp_load, step_en, step_cnt, sel,
    output res_valid, result, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Control stage ahead of the ALU16 16:1 result mux: accepts one opcode at a time,
// steps MUL/DIV for W cycles, then captures the mux output with flags.
//
// state | meaning
// IDLE  | op_ready high, waiting for an opcode
// ITER  | step_en high, W iterations of the shift/add datapath
// CAPT  | mux output, carry and overflow registered into result/flags
// DONE  | res_valid high until the consumer takes the result
module alu_op_sequencer #(
  parameter int W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_op_sequencer_if.slave  bus_if
);

  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [3:0]    OP_MUL   = 4'b1100;
  localparam logic [3:0]    OP_DIV   = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  result_q, result_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_n_q, flag_n_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_v_q, flag_v_d;

  logic          accept;
  logic          multi_cycle;

  // Handshake outputs decode from state only, so res_ready never reaches op_ready.
  assign accept      = bus_if.op_valid && (state_q == IDLE);
  assign multi_cycle = (bus_if.opcode == OP_MUL) || (bus_if.opcode == OP_DIV);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = bus_if.opcode;
          cnt_d = '0;
          state_d = multi_cycle ? ITER : CAPT;
        end
      end
      ITER: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CAPT: begin
        result_d = bus_if.mux_out;
        flag_z_d = (bus_if.mux_out == '0);
        flag_n_d = bus_if.mux_out[W-1];
        flag_c_d = bus_if.c_in;
        flag_v_d = bus_if.v_in;
        state_d  = DONE;
      end
      DONE: begin
        if (bus_if.res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
    end
  end

  assign bus_if.op_ready  = (state_q == IDLE);
  assign bus_if.dp_load   = accept;
  assign bus_if.step_en   = (state_q == ITER);
  assign bus_if.step_cnt  = cnt_q;
  assign bus_if.sel       = sel_q;
  assign bus_if.res_valid = (state_q == DONE);
  assign bus_if.result    = result_q;
  assign bus_if.flag_z    = flag_z_q;
  assign bus_if.flag_n    = flag_n_q;
  assign bus_if.flag_c    = flag_c_q;
  assign bus_if.flag_v    = flag_v_q;

endmodule
